// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with wrap/saturate, wrap pulse and sticky ovf
module mod_counter #(
  parameter int          WIDTH    = 8,
  parameter longint      MODULUS  = 256,
  parameter bit          SATURATE = 1'b0,
  parameter longint      INIT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  logic [WIDTH-1:0] out_q, out_d, ld_v, up_v, dn_v;
  logic             wrap_q, wrap_d, ovf_q, ovf_d, at_max, at_zero, evt;
  // next-state: clear beats load beats count; boundary compare uses MODULUS-1 at WIDTH bits
  always_comb begin
    at_max  = out_q == MAX;
    at_zero = out_q == '0;
    ld_v    = load_val > MAX ? MAX : load_val;
    up_v    = at_max ? (SATURATE ? out_q : '0) : out_q + WIDTH'(1);
    dn_v    = at_zero ? (SATURATE ? out_q : MAX) : out_q - WIDTH'(1);
    evt     = !clear && !load && enable && (up_down ? at_max : at_zero);
    out_d   = clear ? INIT_V : load ? ld_v : !enable ? out_q : up_down ? up_v : dn_v;
    wrap_d  = evt;
    ovf_d   = evt || (ovf_q && !ovf_clr);
  end
  // state register, asynchronously forced to reset values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= INIT_V;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end
  assign out  = out_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
endmodule
